// File: rtl/iram_loader.sv
// iram_loader: instruction RAM with a host load port and a CPU fetch port.
// The host streams a program in while the CPU is held in reset. After the
// last word, the CPU reset is held for RST_HOLD further cycles and is then
// released. From then on the block serves registered, one-cycle-latency
// fetches. A fetch beyond the loaded program returns 0, which is a MIPS nop.
// Optional feature: define IRAM_LOADER_CHECKSUM_EN to add a `checksum` output.
// That output is the modular sum of all accepted load words.
module iram_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W+1:0] pc,
  output logic [DATA_W-1:0] iram_indata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
`ifdef IRAM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W:0]     word_count_r;
  logic [7:0]          hold_cnt_r;
  logic                overflow_r;
  logic                load_ready_r;
  logic                cpu_rst_r;
  logic                load_done_r;
  logic [DATA_W-1:0]   iram_indata_r;

  logic                xfer_s;
  logic                start_accept_s;
  logic [ADDR_W-1:0]   fetch_idx_s;
  logic [DATA_W-1:0]   fetch_data_s;
  logic                unused_pc_s;

  // The low byte-offset bits of pc never select anything; the word index is pc[ADDR_W+1:2].
  assign unused_pc_s = ^pc[1:0];

  // Decode handshakes and the fetch mux; a fetch past the program end reads 0.
  always_comb begin
    xfer_s         = load_valid & load_ready_r & (state_r == ST_LOAD);
    start_accept_s = load_start & ((state_r == ST_IDLE) | (state_r == ST_RUN));
    fetch_idx_s    = pc[ADDR_W+1:2];
    if ({1'b0, fetch_idx_s} < word_count_r) begin
      fetch_data_s = mem_r[fetch_idx_s];
    end else begin
      fetch_data_s = '0;
    end
  end

  // Program storage: written only on an accepted transfer and never cleared.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_r[wr_ptr_r] <= load_data;
    end
  end

  // Loader FSM IDLE -> LOAD -> HOLD -> RUN; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wr_ptr_r      <= '0;
      word_count_r  <= '0;
      hold_cnt_r    <= 8'd0;
      overflow_r    <= 1'b0;
      load_ready_r  <= 1'b0;
      cpu_rst_r     <= 1'b1;
      load_done_r   <= 1'b0;
      iram_indata_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_rst_r     <= 1'b1;
          load_done_r   <= 1'b0;
          iram_indata_r <= '0;
          if (load_start) begin
            state_r      <= ST_LOAD;
            load_ready_r <= 1'b1;
            wr_ptr_r     <= '0;
            word_count_r <= '0;
            overflow_r   <= 1'b0;
          end else begin
            load_ready_r <= 1'b0;
          end
        end

        ST_LOAD: begin
          cpu_rst_r     <= 1'b1;
          load_done_r   <= 1'b0;
          iram_indata_r <= '0;
          if (xfer_s) begin
            word_count_r <= word_count_r + (ADDR_W+1)'(1);
            // The pointer stops at the last slot so a full program never wraps onto word 0.
            if (!(&wr_ptr_r)) begin
              wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end else begin
              wr_ptr_r <= wr_ptr_r;
            end
            if (load_last) begin
              state_r      <= ST_HOLD;
              load_ready_r <= 1'b0;
              hold_cnt_r   <= 8'd0;
            end else if (&wr_ptr_r) begin
              // The RAM is full but the host has not marked a last word.
              overflow_r   <= 1'b1;
              state_r      <= ST_HOLD;
              load_ready_r <= 1'b0;
              hold_cnt_r   <= 8'd0;
            end else begin
              load_ready_r <= 1'b1;
            end
          end else begin
            load_ready_r <= 1'b1;
          end
        end

        ST_HOLD: begin
          load_ready_r  <= 1'b0;
          iram_indata_r <= '0;
          if (hold_cnt_r == 8'(RST_HOLD - 1)) begin
            state_r     <= ST_RUN;
            hold_cnt_r  <= 8'd0;
            cpu_rst_r   <= 1'b0;
            load_done_r <= 1'b1;
          end else begin
            hold_cnt_r  <= hold_cnt_r + 8'd1;
            cpu_rst_r   <= 1'b1;
            load_done_r <= 1'b0;
          end
        end

        ST_RUN: begin
          if (load_start) begin
            // Reload: put the CPU back into reset at once and start a new program.
            state_r       <= ST_LOAD;
            cpu_rst_r     <= 1'b1;
            load_done_r   <= 1'b0;
            load_ready_r  <= 1'b1;
            wr_ptr_r      <= '0;
            word_count_r  <= '0;
            overflow_r    <= 1'b0;
            iram_indata_r <= '0;
          end else begin
            cpu_rst_r     <= 1'b0;
            load_done_r   <= 1'b1;
            load_ready_r  <= 1'b0;
            iram_indata_r <= fetch_data_s;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          load_ready_r  <= 1'b0;
          cpu_rst_r     <= 1'b1;
          load_done_r   <= 1'b0;
          iram_indata_r <= '0;
        end
      endcase
    end
  end

`ifdef IRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  // Running modular sum of accepted words; it restarts with every new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_r <= '0;
    end else if (start_accept_s) begin
      checksum_r <= '0;
    end else if (xfer_s) begin
      checksum_r <= checksum_r + load_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  logic unused_start_s;
  assign unused_start_s = start_accept_s;
`endif

  assign load_ready  = load_ready_r;
  assign iram_indata = iram_indata_r;
  assign cpu_rst     = cpu_rst_r;
  assign load_done   = load_done_r;
  assign word_count  = word_count_r;
  assign overflow    = overflow_r;

endmodule
